// File: rtl/aes_key_pkg.sv
// Shared AES key-schedule definitions: FSM states, word type, RCON and S-box.
package aes_key_pkg;

  localparam int NR_128 = 10;

  typedef logic [31:0] word_t;

  typedef enum logic [2:0] {
    S_IDLE,
    S_PRES,
    S_X3,
    S_X2,
    S_X1,
    S_GGO,
    S_GWT,
    S_W0
  } key_inv_state_t;

  // RCON[1..10], RCON[1] in the top byte
  localparam logic [79:0] RCON_TBL = 80'h01_02_04_08_10_20_40_80_1b_36;

  // Forward AES S-box, entry 0x00 in the top byte
  localparam logic [2047:0] SBOX_TBL = {
    128'h637c777bf26b6fc53001672bfed7ab76,
    128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115,
    128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84,
    128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8,
    128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973,
    128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479,
    128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
    128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df,
    128'h8ca1890dbfe6426841992d0fb054bb16
  };

  function automatic logic [7:0] sbox(input logic [7:0] b);
    return SBOX_TBL[2047 - 8*int'(b) -: 8];
  endfunction

  // Round constant for round r; zero outside 1..10
  function automatic logic [7:0] rcon(input logic [3:0] r);
    if (r == 4'd0 || int'(r) > NR_128) return 8'h00;
    return RCON_TBL[8*(NR_128 - int'(r)) +: 8];
  endfunction

endpackage

// File: rtl/key_inv_g.sv
// g-function of the key schedule: SubWord(RotWord(data_in)), one registered stage.
module key_inv_g
  import aes_key_pkg::*;
(
  input  logic  clk,
  input  logic  reset_n,
  input  logic  g_en,
  input  word_t data_in,
  output word_t data_out,
  output logic  g_valid
);

  word_t w_rot;
  word_t w_sub;
  word_t r_data;
  logic  r_valid;

  assign w_rot = {data_in[23:0], data_in[31:24]};
  assign w_sub = {sbox(w_rot[31:24]), sbox(w_rot[23:16]),
                  sbox(w_rot[15:8]),  sbox(w_rot[7:0])};

  // Capture the substituted word on g_en; valid follows one cycle later
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_data  <= '0;
      r_valid <= 1'b0;
    end else begin
      r_valid <= g_en;
      if (g_en) r_data <= w_sub;
    end
  end

  assign data_out = r_data;
  assign g_valid  = r_valid;

endmodule

// File: rtl/key_inv_exp_128.sv
// Inverse AES-128 key schedule: walks round keys 10 down to 0 on a ready/ack handshake.
module key_inv_exp_128
  import aes_key_pkg::*;
#(
  parameter int NR          = 10,
  parameter bit CLR_ON_IDLE = 1'b0
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         start,
  input  logic [127:0] key_in,
  input  logic         key_ack,
  output logic         key_ready,
  output logic [3:0]   key_round,
  output logic [127:0] key_out,
  output logic         busy,
  output logic         done
);

  key_inv_state_t r_state;
  logic [127:0]   r_key;
  logic [3:0]     r_round;
  logic           r_ready;
  logic           r_busy;
  logic           r_done;
  logic           r_g_en;
  word_t          w_g;
  logic           w_g_valid;

  key_inv_g u_g (
    .clk      (clk),
    .reset_n  (reset_n),
    .g_en     (r_g_en),
    .data_in  (r_key[31:0]),
    .data_out (w_g),
    .g_valid  (w_g_valid)
  );

  // Handshake FSM; one word of the previous round key is recovered per state,
  // w0 last because it needs g() of the already-recovered w3
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= S_IDLE;
      r_key   <= '0;
      r_round <= '0;
      r_ready <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_g_en  <= 1'b0;
    end else begin
      r_done <= 1'b0;
      r_g_en <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_key   <= key_in;
            r_round <= 4'(NR);
            r_ready <= 1'b1;
            r_busy  <= 1'b1;
            r_state <= S_PRES;
          end
        end
        S_PRES: begin
          if (key_ack) begin
            r_ready <= 1'b0;
            if (r_round == 4'd0) begin
              r_busy  <= 1'b0;
              r_done  <= 1'b1;
              r_state <= S_IDLE;
              if (CLR_ON_IDLE) r_key <= '0;
            end else begin
              r_state <= S_X3;
            end
          end
        end
        S_X3: begin
          r_key[31:0] <= r_key[31:0] ^ r_key[63:32];
          r_state     <= S_X2;
        end
        S_X2: begin
          r_key[63:32] <= r_key[63:32] ^ r_key[95:64];
          r_state      <= S_X1;
        end
        S_X1: begin
          r_key[95:64] <= r_key[95:64] ^ r_key[127:96];
          r_g_en       <= 1'b1;
          r_state      <= S_GGO;
        end
        S_GGO: begin
          r_state <= S_GWT;
        end
        S_GWT: begin
          if (w_g_valid) r_state <= S_W0;
        end
        S_W0: begin
          r_key[127:96] <= r_key[127:96] ^ w_g ^ {rcon(r_round), 24'h0};
          r_round       <= r_round - 4'd1;
          r_ready       <= 1'b1;
          r_state       <= S_PRES;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign key_ready = r_ready;
  assign key_round = r_round;
  assign key_out   = r_key;
  assign busy      = r_busy;
  assign done      = r_done;

endmodule

// File: tb/tb_key_inv_exp_128.sv
// Bench for key_inv_exp_128: cycle model of the handshake plus FIPS-197 A.1 literals.
module tb_key_inv_exp_128;

  localparam logic [127:0] R10 = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
  localparam logic [127:0] R9  = 128'hac7766f319fadc2128d12941575c006e;
  localparam logic [127:0] R1  = 128'ha0fafe1788542cb123a339392a6c7605;
  localparam logic [127:0] R0  = 128'h2b7e151628aed2a6abf7158809cf4f3c;

  logic         clk = 1'b0;
  logic         reset_n;
  logic         start;
  logic [127:0] key_in;
  logic         key_ack;
  logic         key_ready;
  logic [3:0]   key_round;
  logic [127:0] key_out;
  logic         busy;
  logic         done;

  int n_chk  = 0;
  int n_fail = 0;
  int cyc    = 0;

  key_inv_exp_128 dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .start     (start),
    .key_in    (key_in),
    .key_ack   (key_ack),
    .key_ready (key_ready),
    .key_round (key_round),
    .key_out   (key_out),
    .busy      (busy),
    .done      (done)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model (GF(2^8) arithmetic) ----------------
  logic [7:0] sb [256];

  function automatic logic [7:0] xt(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = xt(x);
    end
    return p;
  endfunction

  function automatic logic [7:0] rl(input logic [7:0] b, input int n);
    logic [15:0] d;
    d = {b, b} << n;
    return d[15:8];
  endfunction

  task automatic build_sbox();
    logic [7:0] inv;
    for (int x = 0; x < 256; x++) begin
      inv = 8'h00;
      for (int y = 1; y < 256; y++)
        if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
      sb[x] = inv ^ rl(inv, 1) ^ rl(inv, 2) ^ rl(inv, 3) ^ rl(inv, 4) ^ 8'h63;
    end
  endtask

  function automatic logic [7:0] m_rcon(input int r);
    logic [7:0] c;
    c = 8'h01;
    for (int i = 1; i < r; i++) c = xt(c);
    return c;
  endfunction

  // Round r key -> round r-1 key
  function automatic logic [127:0] inv_step(input logic [127:0] k, input int r);
    logic [31:0] w0, w1, w2, w3, t;
    {w0, w1, w2, w3} = k;
    w3 = w3 ^ w2;
    w2 = w2 ^ w1;
    w1 = w1 ^ w0;
    t  = {w3[23:0], w3[31:24]};
    t  = {sb[t[31:24]], sb[t[23:16]], sb[t[15:8]], sb[t[7:0]]};
    w0 = w0 ^ t ^ {m_rcon(r), 24'h0};
    return {w0, w1, w2, w3};
  endfunction

  // Model state: what the outputs must be after the most recent edge
  logic         m_idle, m_ready, m_busy, m_done;
  logic [3:0]   m_round;
  logic [127:0] m_key;
  int           m_gap;

  // Compare against the model on every falling edge, then advance it with the inputs
  // that the next rising edge will sample
  always @(negedge clk) begin
    if (!reset_n) begin
      check("rst_ready", key_ready, 0);
      check("rst_busy",  busy,      0);
      check("rst_done",  done,      0);
      check("rst_round", key_round, 0);
      check("rst_key",   key_out,   0);
      m_idle  <= 1'b1;
      m_ready <= 1'b0;
      m_busy  <= 1'b0;
      m_done  <= 1'b0;
      m_round <= 4'd0;
      m_key   <= '0;
      m_gap   <= 0;
    end else begin
      check("ready", key_ready, m_ready);
      check("busy",  busy,      m_busy);
      check("done",  done,      m_done);
      if (m_ready || m_idle) begin
        check("round", key_round, m_round);
        check("key",   key_out,   m_key);
      end
      m_done <= 1'b0;
      if (m_idle) begin
        if (start) begin
          m_idle  <= 1'b0;
          m_ready <= 1'b1;
          m_busy  <= 1'b1;
          m_key   <= key_in;
          m_round <= 4'd10;
        end
      end else if (m_ready) begin
        if (key_ack) begin
          m_ready <= 1'b0;
          if (m_round == 4'd0) begin
            m_idle <= 1'b1;
            m_busy <= 1'b0;
            m_done <= 1'b1;
          end else begin
            m_gap <= 6;
          end
        end
      end else begin
        m_gap <= m_gap - 1;
        if (m_gap == 1) begin
          m_key   <= inv_step(m_key, int'(m_round));
          m_round <= m_round - 4'd1;
          m_ready <= 1'b1;
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic do_start(input logic [127:0] k);
    @(posedge clk); #1;
    start  = 1'b1;
    key_in = k;
    @(posedge clk); #1;
    start  = 1'b0;
  endtask

  task automatic ack_one();
    @(posedge clk); #1;
    key_ack = 1'b1;
    @(posedge clk); #1;
    key_ack = 1'b0;
  endtask

  task automatic wait_ready(input int maxc, output int n);
    n = -1;
    for (int i = 1; i <= maxc; i++) begin
      @(negedge clk);
      if (key_ready === 1'b1) begin
        n = i;
        break;
      end
    end
    if (n < 0) begin
      n_chk++;
      n_fail++;
      $display("FAIL ready_timeout: key_ready still low after %0d cycles, required high", maxc);
    end
  endtask

  task automatic step(output int n);
    ack_one();
    wait_ready(20, n);
  endtask

  initial begin
    int           n;
    int           t0;
    logic [127:0] k;

    reset_n = 1'b0;
    start   = 1'b0;
    key_ack = 1'b0;
    key_in  = '0;
    build_sbox();

    // Pin the model to the published schedule
    check("pin_model_r9", inv_step(R10, 10), R9);
    k = R10;
    for (int r = 10; r >= 1; r--) begin
      k = inv_step(k, r);
      if (r == 2) check("pin_model_r1", k, R1);
    end
    check("pin_model_r0", k, R0);

    repeat (3) @(posedge clk);
    #1 reset_n = 1'b1;

    // Reset in the middle of a walk
    do_start(R10);
    for (int i = 0; i < 4; i++) step(n);
    @(negedge clk);
    check("mid_round6", key_round, 6);
    @(posedge clk); #1;
    reset_n = 1'b0;
    start   = 1'b1;
    key_ack = 1'b1;
    @(negedge clk);
    check("mid_rst_ready", key_ready, 0);
    check("mid_rst_key",   key_out,   0);
    @(posedge clk); #1;
    reset_n = 1'b1;
    start   = 1'b0;
    key_ack = 1'b0;

    // First load and first backward step
    do_start(R10);
    @(negedge clk);
    check("load_ready", key_ready, 1);
    check("load_round", key_round, 10);
    check("load_key",   key_out,   R10);
    step(n);
    check("step_latency", n, 7);
    check("r9_round", key_round, 9);
    check("r9_key",   key_out,   R9);

    // Down to round 5, then stall with start pulses while busy
    for (int i = 0; i < 4; i++) step(n);
    check("stall_round", key_round, 5);
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      start  = (i % 7 == 3);
      key_in = 128'h0123456789abcdef0123456789abcdef;
    end
    start = 1'b0;
    @(negedge clk);
    check("stall_hold_round", key_round, 5);

    // Stray ack and start while key_ready is low
    ack_one();
    @(posedge clk); #1;
    key_ack = 1'b1;
    @(posedge clk); #1;
    key_ack = 1'b0;
    start   = 1'b1;
    @(posedge clk); #1;
    start   = 1'b0;
    wait_ready(20, n);
    check("stray_round", key_round, 4);

    for (int i = 0; i < 3; i++) step(n);
    check("r1_key", key_out, R1);
    step(n);
    check("r0_round", key_round, 0);
    check("r0_key",   key_out,   R0);

    // Final ack together with start: ack wins
    @(posedge clk); #1;
    key_ack = 1'b1;
    start   = 1'b1;
    key_in  = R10;
    @(posedge clk); #1;
    t0 = cyc + 1;
    @(negedge clk);
    check("final_done",    done,    1);
    check("final_busy",    busy,    0);
    check("final_noload",  key_out, R0);

    // start during the done pulse reloads; ack held high walks the whole schedule
    @(posedge clk); #1;
    start = 1'b0;
    n = -1;
    for (int i = 0; i < 120; i++) begin
      @(negedge clk);
      if (done === 1'b1) begin
        n = cyc - t0;
        break;
      end
    end
    check("walk_cycles", n, 71);
    check("walk_busy",   busy,    0);
    check("walk_key",    key_out, R0);
    key_ack = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("idle_hold_key", key_out, R0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
